// File: rtl/risc_v_32_memarb_if.sv
// risc_v_32_memarb_if
//   Bundles the fetch port, the load/store port and the external memory pins
//   of the unified-memory arbiter.
//   Modports:
//     slave  - the arbiter: takes requests and mem_rdata, drives acks, read
//              data, stall flags and the memory pins.
//     master - the environment (IF/MEM stages plus the memory device).
//   Signals:
//     i_req/i_addr -> i_rdata/i_ack                 fetch port
//     d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack    load/store port
//     stall_if, stall_mem                           pipeline freeze flags
//     mem_ce/mem_we/mem_addr/mem_wdata, mem_rdata   memory pins
interface risc_v_32_memarb_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_ack, d_rdata, d_ack, stall_if, stall_mem,
           mem_ce, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_ack, d_rdata, d_ack, stall_if, stall_mem,
           mem_ce, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/risc_v_32_memarb.sv
// risc_v_32_memarb
//   Arbiter for a single-port unified memory shared by instruction fetch (I)
//   and load/store (D). Each access runs IDLE -> ISSUE -> WAIT -> RESP:
//   one mem_ce cycle, MEM_LAT wait cycles, then a one-cycle ack with the
//   read data. D has strict priority over I.
//   Optional build macro: MEMARB_STARVE_GUARD_EN
//     When defined, a 4-bit streak counter forces an I grant after
//     STREAK_MAX consecutive D grants made while i_req was pending.
//   Parameters:
//     MEM_LAT     cycles from the mem_ce cycle to valid mem_rdata (>= 1)
//     STREAK_MAX  D-grant streak limit for the guard build (1..15)
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  risc_v_32_memarb_if.slave (fetch, load/store and memory pins)
module risc_v_32_memarb #(
  parameter int MEM_LAT    = 1,
  parameter int STREAK_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  risc_v_32_memarb_if.slave        bus
);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("risc_v_32_memarb: MEM_LAT must be >= 1");
  end
  if (STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_bad_streak
    $error("risc_v_32_memarb: STREAK_MAX must be in 1..15");
  end

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          owner_d;
  logic          lat_we;
  logic          grant_i, grant_d;
  logic          wait_done;

`ifdef MEMARB_STARVE_GUARD_EN
  logic [3:0]    streak;
`endif

  assign wait_done = (wait_cnt == CW'(1));

  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef MEMARB_STARVE_GUARD_EN
        if (bus.i_req && (!bus.d_req || streak == 4'(STREAK_MAX)))
          grant_i = 1'b1;
        else if (bus.d_req)
          grant_d = 1'b1;
`else
        if (bus.d_req)
          grant_d = 1'b1;
        else if (bus.i_req)
          grant_i = 1'b1;
`endif
        if (grant_i || grant_d)
          state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // mem_addr/mem_wdata double as the request latch: loaded on grant, shown
  // during ISSUE and held afterwards while mem_ce is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.i_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.mem_ce    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      wait_cnt      <= '0;
      owner_d       <= 1'b0;
      lat_we        <= 1'b0;
    end else begin
      bus.i_ack  <= 1'b0;
      bus.d_ack  <= 1'b0;
      bus.mem_ce <= 1'b0;
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner_d       <= 1'b1;
            lat_we        <= bus.d_we;
            bus.mem_ce    <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
          end else if (grant_i) begin
            owner_d      <= 1'b0;
            lat_we       <= 1'b0;
            bus.mem_ce   <= 1'b1;
            bus.mem_addr <= bus.i_addr;
          end
        end
        ISSUE: wait_cnt <= CW'(MEM_LAT);
        WAIT: begin
          wait_cnt <= wait_cnt - CW'(1);
          // Last wait cycle: capture read data so it is valid with the ack.
          if (wait_done) begin
            if (owner_d) begin
              bus.d_ack   <= 1'b1;
              bus.d_rdata <= lat_we ? '0 : bus.mem_rdata;
            end else begin
              bus.i_ack   <= 1'b1;
              bus.i_rdata <= bus.mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEMARB_STARVE_GUARD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      streak <= '0;
    else if (grant_i)
      streak <= '0;
    else if (grant_d)
      streak <= bus.i_req ? streak + 4'd1 : '0;
  end
`endif

  assign bus.stall_if  = bus.i_req & ~bus.i_ack;
  assign bus.stall_mem = bus.d_req & ~bus.d_ack;

endmodule

// File: tb/tb_risc_v_32_memarb.sv
// tb_risc_v_32_memarb
//   Directed bench for risc_v_32_memarb. Instance dut_a uses MEM_LAT=1 and
//   STREAK_MAX=2; instance dut_b uses MEM_LAT=3. Inputs change 1 ns after the
//   rising edge, outputs are sampled on the falling edge.
module tb_risc_v_32_memarb;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  risc_v_32_memarb_if a();
  risc_v_32_memarb_if b();

  risc_v_32_memarb #(.MEM_LAT(1), .STREAK_MAX(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  risc_v_32_memarb #(.MEM_LAT(3), .STREAK_MAX(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp6 [6];
  int          exp_iack6;
  int          k;
  int          iack_cnt;

  initial begin
    a.i_req = 1'b0; a.i_addr = '0; a.d_req = 1'b0; a.d_we = 1'b0;
    a.d_addr = '0; a.d_wdata = '0; a.mem_rdata = '0;
    b.i_req = 1'b0; b.i_addr = '0; b.d_req = 1'b0; b.d_we = 1'b0;
    b.d_addr = '0; b.d_wdata = '0; b.mem_rdata = '0;
    rst = 1'b1;
`ifdef MEMARB_STARVE_GUARD_EN
    exp6 = '{32'h400, 32'h400, 32'h300, 32'h400, 32'h400, 32'h300};
    exp_iack6 = 2;
`else
    exp6 = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h400, 32'h400};
    exp_iack6 = 0;
`endif

    // Reset state
    @(negedge clk);
    check("rst mem_ce", a.mem_ce, 0);
    check("rst mem_addr", a.mem_addr, 0);
    check("rst i_ack", a.i_ack, 0);
    check("rst d_ack", a.d_ack, 0);
    check("rst i_rdata", a.i_rdata, 0);
    next_cyc(); rst = 1'b0;
    next_cyc();

    // T1: single fetch, MEM_LAT=1
    a.i_req = 1'b1; a.i_addr = 32'h100; a.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("t1 c0 stall_if", a.stall_if, 1);
    check("t1 c0 mem_ce", a.mem_ce, 0);
    next_cyc(); a.i_addr = 32'hFFFFFFFC;
    @(negedge clk);
    check("t1 c1 mem_ce", a.mem_ce, 1);
    check("t1 c1 mem_addr", a.mem_addr, 32'h100);
    check("t1 c1 mem_we", a.mem_we, 0);
    check("t1 c1 stall_if", a.stall_if, 1);
    next_cyc(); a.mem_rdata = 32'h00000013;
    @(negedge clk);
    check("t1 c2 mem_ce", a.mem_ce, 0);
    check("t1 c2 mem_addr hold", a.mem_addr, 32'h100);
    check("t1 c2 stall_if", a.stall_if, 1);
    check("t1 c2 i_ack", a.i_ack, 0);
    next_cyc(); a.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("t1 c3 i_ack", a.i_ack, 1);
    check("t1 c3 i_rdata", a.i_rdata, 32'h13);
    check("t1 c3 stall_if", a.stall_if, 0);
    check("t1 c3 d_ack", a.d_ack, 0);
    next_cyc(); a.i_req = 1'b0;
    @(negedge clk);
    check("t1 c4 i_ack", a.i_ack, 0);
    check("t1 c4 i_rdata hold", a.i_rdata, 32'h13);
    check("t1 c4 mem_ce", a.mem_ce, 0);

    // T2: simultaneous I and D (load); D first
    next_cyc();
    a.i_req = 1'b1; a.i_addr = 32'h104;
    a.d_req = 1'b1; a.d_we = 1'b0; a.d_addr = 32'h2000;
    @(negedge clk);
    check("t2 c0 stall_mem", a.stall_mem, 1);
    next_cyc();
    @(negedge clk);
    check("t2 c1 mem_ce", a.mem_ce, 1);
    check("t2 c1 mem_addr", a.mem_addr, 32'h2000);
    check("t2 c1 mem_we", a.mem_we, 0);
    next_cyc(); a.mem_rdata = 32'h55AA1234;
    @(negedge clk);
    next_cyc(); a.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("t2 c3 d_ack", a.d_ack, 1);
    check("t2 c3 d_rdata", a.d_rdata, 32'h55AA1234);
    check("t2 c3 i_ack", a.i_ack, 0);
    check("t2 c3 stall_if", a.stall_if, 1);
    check("t2 c3 stall_mem", a.stall_mem, 0);
    next_cyc(); a.d_req = 1'b0;
    @(negedge clk);
    check("t2 c4 mem_ce", a.mem_ce, 0);
    check("t2 c4 d_ack", a.d_ack, 0);
    next_cyc();
    @(negedge clk);
    check("t2 c5 mem_ce", a.mem_ce, 1);
    check("t2 c5 mem_addr", a.mem_addr, 32'h104);
    next_cyc(); a.mem_rdata = 32'h00400093;
    @(negedge clk);
    check("t2 c6 i_ack", a.i_ack, 0);
    next_cyc(); a.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("t2 c7 i_ack", a.i_ack, 1);
    check("t2 c7 i_rdata", a.i_rdata, 32'h00400093);
    check("t2 c7 d_rdata hold", a.d_rdata, 32'h55AA1234);
    next_cyc(); a.i_req = 1'b0;

    // T3: store
    next_cyc();
    a.d_req = 1'b1; a.d_we = 1'b1; a.d_addr = 32'h2000; a.d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    next_cyc(); a.d_wdata = 32'h0;
    @(negedge clk);
    check("t3 c1 mem_ce", a.mem_ce, 1);
    check("t3 c1 mem_we", a.mem_we, 1);
    check("t3 c1 mem_addr", a.mem_addr, 32'h2000);
    check("t3 c1 mem_wdata", a.mem_wdata, 32'hDEADBEEF);
    next_cyc(); a.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("t3 c2 mem_we", a.mem_we, 0);
    next_cyc();
    @(negedge clk);
    check("t3 c3 d_ack", a.d_ack, 1);
    check("t3 c3 d_rdata", a.d_rdata, 32'h0);
    check("t3 c3 i_ack", a.i_ack, 0);
    next_cyc(); a.d_req = 1'b0; a.d_we = 1'b0;
    @(negedge clk);
    check("t3 c4 d_ack", a.d_ack, 0);

    // T5: reset in the WAIT cycle of a fetch, then re-request
    next_cyc();
    a.i_req = 1'b1; a.i_addr = 32'h200; a.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    check("t5 c1 mem_ce", a.mem_ce, 1);
    next_cyc(); rst = 1'b1; a.mem_rdata = 32'h77777777;
    @(negedge clk);
    check("t5 rst mem_ce", a.mem_ce, 0);
    check("t5 rst mem_addr", a.mem_addr, 0);
    check("t5 rst mem_wdata", a.mem_wdata, 0);
    check("t5 rst i_ack", a.i_ack, 0);
    check("t5 rst i_rdata", a.i_rdata, 0);
    check("t5 rst stall_if", a.stall_if, 1);
    next_cyc(); rst = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      a.mem_rdata = (c == 5) ? 32'h0000A0B7 : 32'hBAD0BAD0;
      @(negedge clk);
      check($sformatf("t5 c%0d i_ack", c), a.i_ack, (c == 6) ? 1 : 0);
      if (c == 4) check("t5 c4 mem_addr", a.mem_addr, 32'h200);
      if (c == 6) check("t5 c6 i_rdata", a.i_rdata, 32'h0000A0B7);
      next_cyc();
    end
    a.i_req = 1'b0;
    next_cyc();

    // T6: both requests held high; grant order depends on the guard build
    a.i_req = 1'b1; a.i_addr = 32'h300;
    a.d_req = 1'b1; a.d_we = 1'b0; a.d_addr = 32'h400; a.mem_rdata = 32'h0;
    k = 0;
    iack_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (a.mem_ce) begin
        if (k < 6) check($sformatf("t6 grant%0d addr", k), a.mem_addr, exp6[k]);
        k++;
      end
      if (a.i_ack) iack_cnt++;
      next_cyc();
    end
    a.i_req = 1'b0; a.d_req = 1'b0;
    check("t6 grant count", k, 6);
    check("t6 i_ack count", iack_cnt, exp_iack6);
    next_cyc();
    next_cyc();

    // T4: MEM_LAT=3 fetch on dut_b
    b.i_req = 1'b1; b.i_addr = 32'h40; b.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    check("t4 c1 mem_ce", b.mem_ce, 1);
    check("t4 c1 mem_addr", b.mem_addr, 32'h40);
    for (int c = 2; c <= 4; c++) begin
      next_cyc();
      b.mem_rdata = (c == 4) ? 32'h12345678 : 32'hBAD0BAD0;
      @(negedge clk);
      check($sformatf("t4 c%0d mem_ce", c), b.mem_ce, 0);
      check($sformatf("t4 c%0d i_ack", c), b.i_ack, 0);
    end
    next_cyc(); b.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("t4 c5 i_ack", b.i_ack, 1);
    check("t4 c5 i_rdata", b.i_rdata, 32'h12345678);
    next_cyc(); b.i_req = 1'b0;
    @(negedge clk);
    check("t4 c6 i_ack", b.i_ack, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
